// File: rtl/i2s_stereo_receive_pkg.sv
// aud_pkg: shared constants and helpers for the WM8978 ADC-path receiver.
//   AUD_MODE_*  : framing mode encodings (I2S / left-justified)
//   AUD_CH_*    : channel tag encodings carried on rx_chan
//   AUD_IDX_W   : width of the in-slot bit counter
//   aud_extend  : widens a right-aligned word to 32 bits (zero or sign fill)
package aud_pkg;

  localparam int   AUD_MODE_I2S = 0;
  localparam int   AUD_MODE_LJ  = 1;

  localparam logic AUD_CH_LEFT  = 1'b0;
  localparam logic AUD_CH_RIGHT = 1'b1;

  localparam int   AUD_IDX_W    = 6;
  localparam int   AUD_DW       = 32;

  // Bits [31:wl] are filled with bit wl-1 when sx is set, otherwise zero.
  function automatic logic [AUD_DW-1:0] aud_extend(input logic [AUD_DW-1:0] w,
                                                   input int                wl,
                                                   input logic              sx);
    logic [AUD_DW-1:0] r;
    r = '0;
    for (int i = 0; i < AUD_DW; i++)
      r[i] = (i < wl) ? w[i] : (sx & w[wl-1]);
    return r;
  endfunction

endpackage

// File: rtl/i2s_stereo_receive_if.sv
// i2s_stereo_receive_if: codec-side serial inputs plus the word/pair outputs
// seen by the FFT/sample-buffer logic, all in the aud_bclk domain.
//   aud_lrc, aud_adcdat        : framing and serial data from the WM8978
//   rx_done, rx_chan, adc_data : per-word strobe, channel tag, word
//   pair_done, left/right_data : coherent left/right frame strobe and words
//   frame_err                  : truncated-slot strobe
// master = receiver, slave = stream source / word consumer.
interface i2s_stereo_receive_if;
  import aud_pkg::*;

  logic              aud_lrc;
  logic              aud_adcdat;
  logic              rx_done;
  logic              rx_chan;
  logic [AUD_DW-1:0] adc_data;
  logic              pair_done;
  logic [AUD_DW-1:0] left_data;
  logic [AUD_DW-1:0] right_data;
  logic              frame_err;

  modport master (
    input  aud_lrc, aud_adcdat,
    output rx_done, rx_chan, adc_data, pair_done, left_data, right_data, frame_err
  );

  modport slave (
    output aud_lrc, aud_adcdat,
    input  rx_done, rx_chan, adc_data, pair_done, left_data, right_data, frame_err
  );

endinterface

// File: rtl/i2s_stereo_receive_deser.sv
// aud_slot_deser: per-slot deserialiser. Detects LRC edges, runs the in-slot
// bit counter, shifts in the capture window MSB first, and flags word
// completion and truncated slots. Everything here is combinationally valid
// in the cycle the relevant bit is sampled; the top registers the results.
//   aud_bclk, rst_n : bit clock, async active-low reset
//   lrc_i, dat_i    : framing and serial data
//   edge_o          : LRC changed this cycle (start of a new slot)
//   done_o, word_o  : last window bit sampled this cycle; full WL-bit word
//   err_o           : slot ended with a capture in progress
module aud_slot_deser
  import aud_pkg::*;
#(
  parameter int WL   = 24,
  parameter int MODE = AUD_MODE_I2S
) (
  input  logic          aud_bclk,
  input  logic          rst_n,
  input  logic          lrc_i,
  input  logic          dat_i,
  output logic          edge_o,
  output logic          done_o,
  output logic          err_o,
  output logic [WL-1:0] word_o
);

  localparam int OFS  = 1 - MODE;
  localparam int LAST = OFS + WL - 1;

  logic                 lrc_d0_q;
  logic [AUD_IDX_W-1:0] idx_q, idx_d, idx_cur;
  logic                 synced_q, synced_d;
  logic                 busy_q, busy_d;
  // The LSB never needs storing: it is taken straight from dat_i on completion.
  logic [WL-2:0]        shift_q, shift_d;
  logic                 active, in_win;
  int                   ic;

  always_comb begin
    edge_o   = lrc_i ^ lrc_d0_q;
    // The edge cycle is slot position 0 (holds the MSB in left-justified mode).
    idx_cur  = edge_o ? '0 : idx_q;
    idx_d    = (idx_cur == '1) ? idx_cur : idx_cur + 1'b1;
    ic       = int'(idx_cur);
    active   = synced_q | edge_o;
    synced_d = active;
    in_win   = active && (ic >= OFS) && (ic <= LAST);
    done_o   = in_win && (ic == LAST);
    // busy_q still describes the slot that is ending on this edge.
    err_o    = edge_o && synced_q && busy_q;
    word_o   = {shift_q, dat_i};

    shift_d  = edge_o ? '0   : shift_q;
    busy_d   = edge_o ? 1'b0 : busy_q;
    if (in_win) begin
      shift_d = {shift_d[WL-3:0], dat_i};
      busy_d  = ~done_o;
    end
  end

  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      lrc_d0_q <= 1'b0;
      idx_q    <= '0;
      synced_q <= 1'b0;
      busy_q   <= 1'b0;
      shift_q  <= '0;
    end else begin
      lrc_d0_q <= lrc_i;
      idx_q    <= idx_d;
      synced_q <= synced_d;
      busy_q   <= busy_d;
      shift_q  <= shift_d;
    end
  end

endmodule

// File: rtl/i2s_stereo_receive.sv
// i2s_stereo_receive: WM8978 ADC-path serial receiver (I2S or left-justified,
// MSB first, WL-bit words). Produces per-word strobes with a channel tag,
// left-then-right pair strobes, and a truncated-slot error strobe.
//   aud_bclk : bit clock, all logic on its rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : i2s_stereo_receive_if.master (serial in, word/pair/error out)
// Build option: AUD_RX_SIGN_EXT_EN sign-extends words to 32 bits; without it
// the upper bits are zero.
module i2s_stereo_receive
  import aud_pkg::*;
#(
  parameter int WL   = 24,
  parameter int MODE = AUD_MODE_I2S
) (
  input logic                  aud_bclk,
  input logic                  rst_n,
  i2s_stereo_receive_if.master bus
);

`ifdef AUD_RX_SIGN_EXT_EN
  localparam logic SX = 1'b1;
`else
  localparam logic SX = 1'b0;
`endif

  logic              sl_edge, sl_done, sl_err;
  logic [WL-1:0]     sl_word;
  logic [AUD_DW-1:0] word_z, word_x;
  logic              ch_lvl, ch_cur;

  logic              ch_q, ch_d;
  logic              left_ok_q, left_ok_d;
  logic [AUD_DW-1:0] hold_q, hold_d;
  logic              rx_done_q, rx_done_d;
  logic              rx_chan_q, rx_chan_d;
  logic [AUD_DW-1:0] adc_q, adc_d;
  logic              pair_q, pair_d;
  logic [AUD_DW-1:0] left_q, left_d;
  logic [AUD_DW-1:0] right_q, right_d;
  logic              err_q, err_d;

  aud_slot_deser #(.WL(WL), .MODE(MODE)) u_deser (
    .aud_bclk (aud_bclk),
    .rst_n    (rst_n),
    .lrc_i    (bus.aud_lrc),
    .dat_i    (bus.aud_adcdat),
    .edge_o   (sl_edge),
    .done_o   (sl_done),
    .err_o    (sl_err),
    .word_o   (sl_word)
  );

  always_comb begin
    word_z           = '0;
    word_z[WL-1:0]   = sl_word;
    word_x           = aud_extend(word_z, WL, SX);
    // Right channel is lrc=1 in I2S, lrc=0 in left-justified.
    ch_lvl           = (MODE == AUD_MODE_I2S) ? bus.aud_lrc : ~bus.aud_lrc;
    ch_cur           = sl_edge ? ch_lvl : ch_q;
  end

  always_comb begin
    ch_d      = ch_cur;
    left_ok_d = left_ok_q;
    hold_d    = hold_q;
    rx_done_d = 1'b0;
    rx_chan_d = rx_chan_q;
    adc_d     = adc_q;
    pair_d    = 1'b0;
    left_d    = left_q;
    right_d   = right_q;
    err_d     = 1'b0;

    if (sl_err) begin
      err_d     = 1'b1;
      left_ok_d = 1'b0;
    end

    if (sl_done) begin
      rx_done_d = 1'b1;
      rx_chan_d = ch_cur;
      adc_d     = word_x;
      if (ch_cur == AUD_CH_LEFT) begin
        hold_d    = word_x;
        left_ok_d = 1'b1;
      end else if (left_ok_q) begin
        left_d    = hold_q;
        right_d   = word_x;
        pair_d    = 1'b1;
        left_ok_d = 1'b0;
      end
    end
  end

  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q      <= AUD_CH_LEFT;
      left_ok_q <= 1'b0;
      hold_q    <= '0;
      rx_done_q <= 1'b0;
      rx_chan_q <= AUD_CH_LEFT;
      adc_q     <= '0;
      pair_q    <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      ch_q      <= ch_d;
      left_ok_q <= left_ok_d;
      hold_q    <= hold_d;
      rx_done_q <= rx_done_d;
      rx_chan_q <= rx_chan_d;
      adc_q     <= adc_d;
      pair_q    <= pair_d;
      left_q    <= left_d;
      right_q   <= right_d;
      err_q     <= err_d;
    end
  end

  assign bus.rx_done    = rx_done_q;
  assign bus.rx_chan    = rx_chan_q;
  assign bus.adc_data   = adc_q;
  assign bus.pair_done  = pair_q;
  assign bus.left_data  = left_q;
  assign bus.right_data = right_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_i2s_stereo_receive.sv
// Directed bench for i2s_stereo_receive. Three instances cover
// WL24/I2S, WL16/left-justified and WL32/I2S; a negedge monitor counts
// strobes and latches the words they carry.
module tb_i2s_stereo_receive;
  import aud_pkg::*;

  logic aud_bclk = 1'b0;
  logic rst_n    = 1'b0;
  always #5 aud_bclk = ~aud_bclk;

  logic [2:0] lrc = '0;
  logic [2:0] dat = '0;

`ifdef AUD_RX_SIGN_EXT_EN
  localparam logic [31:0] EXP_R0 = 32'hFFABCDEF;
  localparam logic [31:0] EXP_L1 = 32'hFFFF8001;
`else
  localparam logic [31:0] EXP_R0 = 32'h00ABCDEF;
  localparam logic [31:0] EXP_L1 = 32'h00008001;
`endif

  i2s_stereo_receive_if if0 ();
  i2s_stereo_receive_if if1 ();
  i2s_stereo_receive_if if2 ();

  assign if0.aud_lrc = lrc[0];  assign if0.aud_adcdat = dat[0];
  assign if1.aud_lrc = lrc[1];  assign if1.aud_adcdat = dat[1];
  assign if2.aud_lrc = lrc[2];  assign if2.aud_adcdat = dat[2];

  i2s_stereo_receive #(.WL(24), .MODE(0)) dut0 (.aud_bclk(aud_bclk), .rst_n(rst_n), .bus(if0));
  i2s_stereo_receive #(.WL(16), .MODE(1)) dut1 (.aud_bclk(aud_bclk), .rst_n(rst_n), .bus(if1));
  i2s_stereo_receive #(.WL(32), .MODE(0)) dut2 (.aud_bclk(aud_bclk), .rst_n(rst_n), .bus(if2));

  logic [2:0]  rxd, prd, erd, rxc;
  logic [31:0] adc [3];
  logic [31:0] ldt [3];
  logic [31:0] rdt [3];
  assign rxd = {if2.rx_done,   if1.rx_done,   if0.rx_done};
  assign prd = {if2.pair_done, if1.pair_done, if0.pair_done};
  assign erd = {if2.frame_err, if1.frame_err, if0.frame_err};
  assign rxc = {if2.rx_chan,   if1.rx_chan,   if0.rx_chan};
  assign adc[0] = if0.adc_data;   assign adc[1] = if1.adc_data;   assign adc[2] = if2.adc_data;
  assign ldt[0] = if0.left_data;  assign ldt[1] = if1.left_data;  assign ldt[2] = if2.left_data;
  assign rdt[0] = if0.right_data; assign rdt[1] = if1.right_data; assign rdt[2] = if2.right_data;

  int          rx_cnt [3];
  int          pr_cnt [3];
  int          er_cnt [3];
  int          bad_pr [3];
  logic [31:0] last_d [3];
  logic        last_c [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      rx_cnt[i] = 0; pr_cnt[i] = 0; er_cnt[i] = 0; bad_pr[i] = 0;
      last_d[i] = '0; last_c[i] = 1'b0;
    end
  end

  // pair_done must only ever appear together with a right-channel rx_done.
  always @(negedge aud_bclk) begin
    for (int i = 0; i < 3; i++) begin
      if (rxd[i]) begin
        rx_cnt[i] <= rx_cnt[i] + 1;
        last_d[i] <= adc[i];
        last_c[i] <= rxc[i];
      end
      if (prd[i]) begin
        pr_cnt[i] <= pr_cnt[i] + 1;
        if (!(rxd[i] && rxc[i])) bad_pr[i] <= bad_pr[i] + 1;
      end
      if (erd[i]) er_cnt[i] <= er_cnt[i] + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aud_bclk);
    #1;
  endtask

  // One slot of len BCLKs at LRC level lv; window bits carry w MSB first,
  // every other cycle drives pad.
  task automatic send_slot(input int d, input logic lv, input int len, input int ofs,
                           input int wl, input logic [31:0] w, input logic pad);
    for (int k = 0; k < len; k++) begin
      @(negedge aud_bclk);
      lrc[d] = lv;
      if (k >= ofs && k < ofs + wl) dat[d] = w[wl-1-(k-ofs)];
      else                          dat[d] = pad;
    end
    #1;
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, ".rx_done"},    32'(if0.rx_done),   32'd0);
    chk({tag, ".rx_chan"},    32'(if0.rx_chan),   32'd0);
    chk({tag, ".adc_data"},   if0.adc_data,       32'd0);
    chk({tag, ".pair_done"},  32'(if0.pair_done), 32'd0);
    chk({tag, ".left_data"},  if0.left_data,      32'd0);
    chk({tag, ".right_data"}, if0.right_data,     32'd0);
    chk({tag, ".frame_err"},  32'(if0.frame_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    idle(3);
    chk_zero0("rst");
    chk("rst.d1_rx_done", 32'(if1.rx_done), 32'd0);
    chk("rst.d2_adc",     if2.adc_data,     32'd0);
    @(negedge aud_bclk);
    rst_n = 1'b1;

    // Stream joined mid left slot: no activity until the first LRC edge
    for (int k = 0; k < 10; k++) begin
      @(negedge aud_bclk);
      dat[0] = k[0];
    end
    idle(1);
    chk("mid.rx_cnt", rx_cnt[0], 0);
    chk("mid.er_cnt", er_cnt[0], 0);

    // First full slot is the right channel: word but no pair
    send_slot(0, 1'b1, 32, 1, 24, 32'h00ABCDEF, 1'b1);
    chk("sync.rx_cnt", rx_cnt[0], 1);
    chk("sync.chan",   32'(last_c[0]), 32'd1);
    chk("sync.data",   last_d[0], EXP_R0);
    chk("sync.pr_cnt", pr_cnt[0], 0);
    chk("sync.er_cnt", er_cnt[0], 0);

    // Full frame: left then right pairs
    send_slot(0, 1'b0, 32, 1, 24, 32'h00123456, 1'b1);
    chk("i2s.l_rx_cnt", rx_cnt[0], 2);
    chk("i2s.l_chan",   32'(last_c[0]), 32'd0);
    chk("i2s.l_data",   last_d[0], 32'h00123456);
    send_slot(0, 1'b1, 32, 1, 24, 32'h00ABCDEF, 1'b1);
    chk("i2s.r_rx_cnt", rx_cnt[0], 3);
    chk("i2s.r_data",   last_d[0], EXP_R0);
    chk("i2s.pr_cnt",   pr_cnt[0], 1);
    chk("i2s.left",     ldt[0], 32'h00123456);
    chk("i2s.right",    rdt[0], EXP_R0);

    // Truncated 20-BCLK left slot, then right word without a pair
    send_slot(0, 1'b0, 20, 1, 24, 32'h00123456, 1'b1);
    send_slot(0, 1'b1, 32, 1, 24, 32'h00654321, 1'b1);
    chk("trunc.er_cnt", er_cnt[0], 1);
    chk("trunc.rx_cnt", rx_cnt[0], 4);
    chk("trunc.chan",   32'(last_c[0]), 32'd1);
    chk("trunc.data",   last_d[0], 32'h00654321);
    chk("trunc.pr_cnt", pr_cnt[0], 1);
    chk("trunc.left",   ldt[0], 32'h00123456);
    send_slot(0, 1'b0, 32, 1, 24, 32'h000F0F0F, 1'b1);
    send_slot(0, 1'b1, 32, 1, 24, 32'h0000FF00, 1'b1);
    chk("recov.pr_cnt", pr_cnt[0], 2);
    chk("recov.left",   ldt[0], 32'h000F0F0F);
    chk("recov.right",  rdt[0], 32'h0000FF00);
    chk("recov.er_cnt", er_cnt[0], 1);

    // Reset pulse in the idx=10 cycle of a left slot
    send_slot(0, 1'b0, 10, 1, 24, 32'h00111111, 1'b1);
    @(negedge aud_bclk);
    dat[0] = 1'b1;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    idle(1);
    chk_zero0("rstp");
    send_slot(0, 1'b0, 21, 1, 0, 32'h0, 1'b1);
    chk("rstp.er_cnt", er_cnt[0], 1);
    chk("rstp.rx_cnt", rx_cnt[0], 6);
    send_slot(0, 1'b1, 32, 1, 24, 32'h000A0B0C, 1'b1);
    chk("rstp.rx_cnt2", rx_cnt[0], 7);
    chk("rstp.data",    last_d[0], 32'h000A0B0C);
    chk("rstp.pr_cnt",  pr_cnt[0], 2);
    chk("rstp.er_cnt2", er_cnt[0], 1);

    // Left-justified, WL16, back-to-back minimum-length slots
    send_slot(1, 1'b1, 16, 0, 16, 32'h00008001, 1'b1);
    send_slot(1, 1'b0, 16, 0, 16, 32'h00007FFE, 1'b1);
    send_slot(1, 1'b1, 16, 0, 16, 32'h00008001, 1'b1);
    send_slot(1, 1'b0, 16, 0, 16, 32'h00007FFE, 1'b1);
    idle(2);
    chk("lj.rx_cnt", rx_cnt[1], 4);
    chk("lj.pr_cnt", pr_cnt[1], 2);
    chk("lj.er_cnt", er_cnt[1], 0);
    chk("lj.left",   ldt[1], EXP_L1);
    chk("lj.right",  rdt[1], 32'h00007FFE);
    chk("lj.chan",   32'(last_c[1]), 32'd1);

    // WL32 with a 100-BCLK left slot: counter saturates, single strobe
    send_slot(2, 1'b1, 1, 1, 32, 32'h0, 1'b1);
    send_slot(2, 1'b0, 100, 1, 32, 32'h80000000, 1'b1);
    chk("w32.rx_cnt", rx_cnt[2], 1);
    chk("w32.data",   last_d[2], 32'h80000000);
    chk("w32.chan",   32'(last_c[2]), 32'd0);
    send_slot(2, 1'b1, 64, 1, 32, 32'h00000001, 1'b1);
    idle(1);
    chk("w32.rx_cnt2", rx_cnt[2], 2);
    chk("w32.pr_cnt",  pr_cnt[2], 1);
    chk("w32.left",    ldt[2], 32'h80000000);
    chk("w32.right",   rdt[2], 32'h00000001);
    chk("w32.er_cnt",  er_cnt[2], 0);

    chk("pair_coinc0", bad_pr[0], 0);
    chk("pair_coinc1", bad_pr[1], 0);
    chk("pair_coinc2", bad_pr[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
